// File: rtl/req_rsp_responder_pkg.sv
// Shared types and constants for the request/response responder.
package req_rsp_responder_pkg;

  // Field widths of a queued request; the top's ADDR_W/DATA_W must match these.
  localparam int REQ_ADDR_W = 8;
  localparam int REQ_DATA_W = 32;

  // Backpressure LFSR: x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form,
  // feedback is the XOR of bits 0, 2, 3 and 5 shifted into bit 15.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } rsp_state_e;

  typedef struct packed {
    logic                  write;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
  } req_entry_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/req_rsp_fifo.sv
// Synchronous in-order queue of pending requests. Pointers carry one extra
// wrap bit so full and empty are told apart without a separate counter.
module req_rsp_fifo
  import req_rsp_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  req_entry_t               din,
  output req_entry_t               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  req_entry_t      mem_q [DEPTH];
  logic [PW:0]     wr_ptr_q, wr_ptr_d;
  logic [PW:0]     rd_ptr_q, rd_ptr_d;
  logic            do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign dout    = mem_q[rd_ptr_q[PW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next pointer values; a guarded push/pop never over- or under-runs.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (PW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (PW+1)'(do_pop);
  end

  // Pointer registers; reset empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= din;
  end

endmodule

// File: rtl/req_rsp_responder.sv
// Responder side of the request/response agent: queues requests, waits
// cfg_latency, executes each against a word memory and returns one response
// per request, strictly in order.
// Optional build macro REQ_RSP_RESPONDER_BACKPRESSURE_EN adds an LFSR that
// randomly withholds req_ready to exercise initiator stalls.
//
// Handshakes: a beat transfers on a rising edge where valid && ready. A
// source holds valid and its payload stable until that edge; ready never
// depends combinationally on valid on the same channel.
module req_rsp_responder
  import req_rsp_responder_pkg::*;
#(
  parameter int ADDR_W     = REQ_ADDR_W,
  parameter int DATA_W     = REQ_DATA_W,
  parameter int MEM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int LAT_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LAT_W-1:0]  cfg_latency,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output rsp_state_e        dbg_state
);

  localparam int MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  rsp_state_e          state_q, state_d;
  logic [LAT_W-1:0]    cnt_q, cnt_d;
  req_entry_t          cur_q, cur_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                ready_en_q, ready_en_d;

  logic [DATA_W-1:0]   mem_q [MEM_WORDS];
  logic                mem_we;
  logic [MEM_AW-1:0]   mem_idx;
  logic                in_range;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  req_entry_t          fifo_din, fifo_dout;
  logic [CNT_W-1:0]    fifo_count;

  assign fifo_din  = '{write: req_write, addr: req_addr, wdata: req_wdata};
  assign fifo_push = req_valid && req_ready;

  req_rsp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef REQ_RSP_RESPONDER_BACKPRESSURE_EN
  logic [15:0] lfsr_q, lfsr_d;

  // LFSR free-runs every cycle; its bit0 vetoes req_ready.
  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
  end

  // LFSR register restarts from the seed on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign req_ready = ready_en_q && !fifo_full && !lfsr_q[0];
`else
  assign req_ready = ready_en_q && !fifo_full;
`endif

  assign in_range  = ({1'b0, cur_q.addr} < (ADDR_W+1)'(MEM_WORDS));
  assign mem_idx   = cur_q.addr[MEM_AW-1:0];
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (fifo_count != '0) || (state_q != IDLE);
  assign dbg_state = state_q;

  // Sequencer: pop, count down, execute, then hold the response until taken.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_d       = cur_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    ready_en_d  = 1'b1;
    fifo_pop    = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = fifo_dout;
          cnt_d    = cfg_latency;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          mem_we      = cur_q.write && in_range;
          rsp_err_d   = !in_range;
          rsp_rdata_d = (!cur_q.write && in_range) ? mem_q[mem_idx] : '0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            cur_d    = fifo_dout;
            cnt_d    = cfg_latency;
            state_d  = WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers; reset drops all in-flight work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      ready_en_q  <= ready_en_d;
    end
  end

  // Word memory; cleared on reset, written only by in-range writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[mem_idx] <= cur_q.wdata;
    end
  end

endmodule

// File: tb/tb_req_rsp_responder.sv
// Directed plus random bench for req_rsp_responder with an in-order
// scoreboard of expected {err, rdata} responses.
module tb_req_rsp_responder;
  import req_rsp_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cfg_latency;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        busy;
  rsp_state_e  dbg_state;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          rsp_seen = 0;
  int          last_acc_cyc = 0;
  logic [32:0] exp_q[$];
  int          rise_q[$];
  logic [31:0] mem_m [64];
  logic [15:0] lfsr_m;

  req_rsp_responder dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_latency (cfg_latency),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Independent model of the backpressure LFSR (taps 16,14,13,11).
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= 16'hACE1;
    else     lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
  end

  function automatic logic exp_ready_gate();
`ifdef REQ_RSP_RESPONDER_BACKPRESSURE_EN
    return !lfsr_m[0];
`else
    return 1'b1;
`endif
  endfunction

  // ---------------- check helper ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [32:0] model_exec(input logic w, input logic [7:0] a, input logic [31:0] d);
    if (a >= 8'd64) return {1'b1, 32'h0};
    if (w) begin
      mem_m[a[5:0]] = d;
      return 33'h0;
    end
    return {1'b0, mem_m[a[5:0]]};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) mem_m[i] = 32'h0;
    exp_q.delete();
    rise_q.delete();
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic w, input logic [7:0] a, input logic [31:0] d);
    int   guard = 0;
    logic acc   = 1'b0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    while (!acc && guard < 300) begin
      @(negedge clk);
      acc = req_ready;
      if (acc) last_acc_cyc = cyc;
      step();
      guard++;
    end
    chk("req_accept", 64'(acc), 64'(1));
    if (acc) exp_q.push_back(model_exec(w, a, d));
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int g = 0;
    while (exp_q.size() != 0 && g < 600) begin
      step();
      g++;
    end
    chk({tag, "_drain"}, 64'(exp_q.size()), 64'(0));
    step();
    step();
    @(negedge clk);
    chk({tag, "_idle_busy"}, 64'(busy), 64'(0));
    step();
  endtask

  // ---------------- response monitor / scoreboard ----------------
  logic        hold_v = 1'b0;
  logic        prev_v = 1'b0;
  logic [32:0] hold_val;
  logic [32:0] exp_e;

  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
      prev_v = 1'b0;
    end else begin
      if (rsp_valid && !prev_v) rise_q.push_back(cyc);
      if (rsp_valid && hold_v) chk("rsp_hold_stable", 64'({rsp_err, rsp_rdata}), 64'(hold_val));
      if (rsp_valid && rsp_ready) begin
        rsp_seen++;
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
        end else begin
          exp_e = exp_q.pop_front();
          chk("rsp_data", 64'({rsp_err, rsp_rdata}), 64'(exp_e));
        end
        hold_v = 1'b0;
      end else if (rsp_valid) begin
        hold_v   = 1'b1;
        hold_val = {rsp_err, rsp_rdata};
      end else begin
        hold_v = 1'b0;
      end
      prev_v = rsp_valid;
    end
  end

`ifdef REQ_RSP_RESPONDER_BACKPRESSURE_EN
  // Ready must be withheld on every cycle the LFSR bit0 is set.
  always @(negedge clk) begin
    if (!rst && lfsr_m[0]) chk("bp_ready_low", 64'(req_ready), 64'(0));
  end
`endif

  // ---------------- directed sequence ----------------
  initial begin
    int acc_first;
    int seen_before;
    int n_rand;
    rst         = 1'b1;
    cfg_latency = 4'd2;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = 8'h0;
    req_wdata   = 32'h0;
    rsp_ready   = 1'b1;
    model_reset();

    // Reset: outputs quiet while held, ready in the first cycle after.
    repeat (3) step();
    @(negedge clk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_busy",      64'(busy),      64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rdata",     64'(rsp_rdata), 64'(0));
    chk("rst_err",       64'(rsp_err),   64'(0));
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("post_rst_req_ready", 64'(req_ready), 64'(exp_ready_gate()));
    chk("post_rst_busy",      64'(busy),      64'(0));
    step();

    // Write then read addr 5 with latency 2.
    rise_q.delete();
    cfg_latency = 4'd2;
    send(1'b1, 8'd5, 32'hDEAD_BEEF);
    acc_first = last_acc_cyc;
    send(1'b0, 8'd5, 32'h0);
    wait_drain("wr_rd");
    chk("wr_rd_nrsp", 64'(rise_q.size()), 64'(2));
    if (rise_q.size() > 0) chk("wr_rd_latency", 64'(rise_q[0] - acc_first), 64'(5));

    // Minimum latency with cfg_latency=0.
    rise_q.delete();
    cfg_latency = 4'd0;
    send(1'b0, 8'd5, 32'h0);
    acc_first = last_acc_cyc;
    wait_drain("lat0");
    if (rise_q.size() > 0) chk("lat0_latency", 64'(rise_q[0] - acc_first), 64'(3));
    else chk("lat0_nrsp", 64'(rise_q.size()), 64'(1));

    // Out of range at addr 64, boundary at 63, word 0 must survive.
    cfg_latency = 4'd1;
    send(1'b1, 8'd0,  32'h1234_5678);
    send(1'b1, 8'd64, 32'hFFFF_FFFF);
    send(1'b0, 8'd64, 32'h0);
    send(1'b1, 8'd63, 32'hA5A5_0063);
    send(1'b0, 8'd63, 32'h0);
    send(1'b0, 8'd0,  32'h0);
    send(1'b0, 8'd255, 32'h0);
    wait_drain("oor");

    // Queue full with the response stalled.
    cfg_latency = 4'd0;
    rsp_ready   = 1'b0;
    send(1'b0, 8'd5,  32'h0);
    send(1'b1, 8'd10, 32'h0000_AAAA);
    send(1'b0, 8'd10, 32'h0);
    send(1'b1, 8'd11, 32'h0000_BBBB);
    send(1'b0, 8'd11, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("full_req_ready", 64'(req_ready), 64'(0));
      chk("full_rsp_valid", 64'(rsp_valid), 64'(1));
      chk("full_busy",      64'(busy),      64'(1));
      step();
    end
    rsp_ready = 1'b1;
    wait_drain("full");

    // Reset while in WAIT with three requests queued.
    cfg_latency = 4'd15;
    send(1'b1, 8'd20, 32'h0000_CAFE);
    send(1'b0, 8'd20, 32'h0);
    send(1'b1, 8'd21, 32'h0000_F00D);
    send(1'b0, 8'd21, 32'h0);
    @(negedge clk);
    chk("mid_state_wait", 64'(dbg_state), 64'(WAIT));
    step();
    rst = 1'b1;
    model_reset();
    seen_before = rsp_seen;
    step();
    step();
    rst = 1'b0;
    repeat (30) step();
    chk("mid_no_rsp", 64'(rsp_seen - seen_before), 64'(0));
    @(negedge clk);
    chk("mid_busy", 64'(busy), 64'(0));
    step();
    cfg_latency = 4'd1;
    send(1'b0, 8'd5,  32'h0);
    send(1'b0, 8'd20, 32'h0);
    wait_drain("mid_rd");

    // Random traffic: every request answered once, in order.
`ifdef REQ_RSP_RESPONDER_BACKPRESSURE_EN
    n_rand = 100;
`else
    n_rand = 40;
`endif
    seen_before = rsp_seen;
    for (int i = 0; i < n_rand; i++) begin
      cfg_latency = 4'($urandom_range(0, 2));
      send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 67)), $urandom);
    end
    wait_drain("rand");
    chk("rand_count", 64'(rsp_seen - seen_before), 64'(n_rand));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
